// File: rtl/mem_load_store_ctrl.sv
// Load/store sequencer between core control, register file and a 16-bit data memory.
// One outstanding req/ack transaction with a bounded wait; loads write back through a one-cycle memLoad strobe.
module mem_load_store_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] addr,
  input  logic [2:0]  dst_sel,
  input  logic [15:0] reg_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  reg_sel,
  output logic [15:0] write_data,
  output logic        memLoad
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_FIN} state_t;

  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

  state_t           r_state, w_next;
  logic             r_is_store;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_dst;
  logic [2:0]       r_reg_sel;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [15:0]      r_write_data;
  logic             w_hit;

  // The cycle whose increment would reach TIMEOUT is the last one we wait through.
  assign w_hit = (r_cnt == LP_TMO - CNT_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ: begin
        if (mem_ack)    w_next = r_is_store ? S_FIN : S_WB;
        else if (w_hit) w_next = S_FIN;
      end
      S_WB:    w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_dst        <= 3'b000;
      r_reg_sel    <= 3'b000;
      r_addr       <= 16'h0000;
      r_wdata      <= 16'h0000;
      r_write_data <= 16'h0000;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store <= is_store;
            r_addr     <= addr;
            r_dst      <= dst_sel;
            r_wdata    <= reg_val;
            r_cnt      <= '0;
            r_err      <= 1'b0;
          end
        end
        S_REQ: begin
          if (r_cnt != LP_TMO) r_cnt <= r_cnt + CNT_W'(1);
          // Ack wins over a simultaneous timeout.
          if (mem_ack) begin
            if (!r_is_store) begin
              r_write_data <= mem_rdata;
              r_reg_sel    <= r_dst;
            end
          end else if (w_hit) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_REQ) || (r_state == S_WB);
  assign mem_req    = (r_state == S_REQ);
  assign mem_we     = (r_state == S_REQ) && r_is_store;
  assign memLoad    = (r_state == S_WB);
  assign done       = (r_state == S_FIN);
  assign err        = (r_state == S_FIN) && r_err;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign reg_sel    = r_reg_sel;
  assign write_data = r_write_data;

endmodule

// File: tb/tb_mem_load_store_ctrl.sv
// Directed bench for mem_load_store_ctrl: load, store, timeout, ack-at-limit, start flooding, mid-transaction reset.
module tb_mem_load_store_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [15:0] addr, reg_val, mem_rdata;
  logic [2:0]  dst_sel;
  logic        mem_ack;
  logic        busy, done, err, mem_req, mem_we, memLoad;
  logic [15:0] mem_addr, mem_wdata, write_data;
  logic [2:0]  reg_sel;

  int checks = 0;
  int errors = 0;

  mem_load_store_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .addr(addr),
    .dst_sel(dst_sel), .reg_val(reg_val), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .reg_sel(reg_sel),
    .write_data(write_data), .memLoad(memLoad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nreq, nld, ndone;
    rst_n = 1'b0; start = 0; is_store = 0; addr = 0; reg_val = 0; dst_sel = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);  chk("rst_done", done, 0);   chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);  chk("rst_ld", memLoad, 0);  chk("rst_wd", write_data, 0);
    chk("rst_sel", reg_sel, 0); chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Load, ack in 2nd REQ cycle
    start = 1; is_store = 0; addr = 16'h0040; dst_sel = 3; reg_val = 16'h7777;
    tick(); start = 0;                                       // cycle 1
    chk("ld_busy1", busy, 1); chk("ld_req1", mem_req, 1); chk("ld_we", mem_we, 0);
    chk("ld_addr", mem_addr, 16'h0040);
    tick(); mem_ack = 1; mem_rdata = 16'hBEEF;               // cycle 2
    chk("ld_req2", mem_req, 1); chk("ld_nodone2", done, 0);
    tick(); mem_ack = 0; mem_rdata = 16'h0000;               // cycle 3 WB
    chk("ld_wb_ld", memLoad, 1); chk("ld_wb_sel", reg_sel, 3); chk("ld_wb_wd", write_data, 16'hBEEF);
    chk("ld_wb_req", mem_req, 0); chk("ld_wb_busy", busy, 1); chk("ld_wb_done", done, 0);
    tick();                                                  // cycle 4 FIN
    chk("ld_done", done, 1); chk("ld_err", err, 0); chk("ld_fin_busy", busy, 0); chk("ld_fin_ld", memLoad, 0);
    tick();
    chk("ld_idle_done", done, 0); chk("ld_hold_wd", write_data, 16'hBEEF); chk("ld_hold_sel", reg_sel, 3);

    // Store, ack in 1st REQ cycle
    start = 1; is_store = 1; addr = 16'h0010; reg_val = 16'h1234; dst_sel = 5;
    tick(); start = 0; mem_ack = 1;                          // cycle 1
    chk("st_req", mem_req, 1); chk("st_we", mem_we, 1); chk("st_wdata", mem_wdata, 16'h1234);
    chk("st_addr", mem_addr, 16'h0010); chk("st_ld1", memLoad, 0);
    tick(); mem_ack = 0;                                     // cycle 2 FIN
    chk("st_done", done, 1); chk("st_err", err, 0); chk("st_ld2", memLoad, 0); chk("st_req2", mem_req, 0);
    chk("st_wd_keep", write_data, 16'hBEEF); chk("st_sel_keep", reg_sel, 3);
    tick();

    // Timeout: load with no ack
    start = 1; is_store = 0; addr = 16'h0100; dst_sel = 1;
    tick(); start = 0;
    nreq = 0; nld = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (mem_req) nreq++;
      if (memLoad) nld++;
      tick();
    end
    chk("to_done", done, 1); chk("to_err", err, 1); chk("to_nreq", nreq, 15);
    chk("to_nld", nld, 0); chk("to_req_low", mem_req, 0); chk("to_wd_keep", write_data, 16'hBEEF);
    tick();
    chk("to_err_pulse", err, 0);

    // Ack on the 15th REQ cycle wins over timeout
    start = 1; is_store = 0; addr = 16'h0200; dst_sel = 6;
    tick(); start = 0;                                       // REQ cycle 1
    for (int i = 1; i < 15; i++) tick();                     // REQ cycle 15
    chk("a15_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'hA5A5;
    tick(); mem_ack = 0;
    chk("a15_ld", memLoad, 1); chk("a15_wd", write_data, 16'hA5A5); chk("a15_sel", reg_sel, 6);
    tick();
    chk("a15_done", done, 1); chk("a15_err", err, 0);
    tick();

    // start held high through a load: only first accepted, next accepted after FIN
    start = 1; is_store = 0; addr = 16'h0300; dst_sel = 2;
    ndone = 0;
    tick(); mem_ack = 1; mem_rdata = 16'h1111;               // cycle 1 REQ
    addr = 16'h0400; dst_sel = 4;
    tick(); mem_ack = 0;                                     // cycle 2 WB
    chk("sp_addr_latched", mem_addr, 16'h0300); chk("sp_sel", reg_sel, 2);
    tick(); if (done) ndone++;                               // cycle 3 FIN
    chk("sp_fin_done", done, 1);
    tick(); if (done) ndone++;                               // cycle 4 IDLE, start sampled
    chk("sp_ndone", ndone, 1); chk("sp_idle_busy", busy, 0);
    tick(); start = 0;                                       // cycle 5 REQ of second
    chk("sp_second_busy", busy, 1); chk("sp_second_addr", mem_addr, 16'h0400);
    mem_ack = 1; mem_rdata = 16'h2222;
    tick(); mem_ack = 0;
    chk("sp_second_wd", write_data, 16'h2222); chk("sp_second_sel", reg_sel, 4);
    tick(); tick();

    // Reset while waiting for ack
    start = 1; is_store = 0; addr = 16'h0500; dst_sel = 7;
    tick(); start = 0;
    chk("rs_req", mem_req, 1);
    #2 rst_n = 1'b0; #1;
    chk("rs_busy", busy, 0); chk("rs_req0", mem_req, 0); chk("rs_wd0", write_data, 0);
    chk("rs_addr0", mem_addr, 0); chk("rs_done0", done, 0);
    @(negedge clk); rst_n = 1'b1; mem_ack = 1; mem_rdata = 16'hDEAD;
    tick(); mem_ack = 0;
    chk("rs_late_ack_ld", memLoad, 0); chk("rs_late_ack_wd", write_data, 0); chk("rs_late_busy", busy, 0);
    start = 1; is_store = 0; addr = 16'h0600; dst_sel = 1;
    tick(); start = 0; mem_ack = 1; mem_rdata = 16'h5A5A;
    tick(); mem_ack = 0;
    chk("rs_new_ld", memLoad, 1); chk("rs_new_wd", write_data, 16'h5A5A); chk("rs_new_sel", reg_sel, 1);
    tick();
    chk("rs_new_done", done, 1); chk("rs_new_err", err, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
